// File: rtl/chevychev_hp_pkg.sv
// Shared widths, default coefficients and output limits for the Chebyshev high-pass biquad.
// Optional saturation is selected by CHEVYCHEV_HP_SAT_EN (see chevychev_hp_limit).
package chevychev_hp_pkg;

  localparam int unsigned IN_W      = 8;
  localparam int unsigned OUT_W     = 18;
  localparam int unsigned COEF_W    = 10;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned FRAC_BITS = 8;

  // Q2.8 defaults: zero DC gain, 0.8 gain at Nyquist
  localparam logic signed [COEF_W-1:0] B0_DEF = 10'sd64;
  localparam logic signed [COEF_W-1:0] B1_DEF = -10'sd128;
  localparam logic signed [COEF_W-1:0] B2_DEF = 10'sd64;
  localparam logic signed [COEF_W-1:0] A1_DEF = 10'sd0;
  localparam logic signed [COEF_W-1:0] A2_DEF = 10'sd64;

  localparam logic signed [OUT_W-1:0] Y_MAX = 18'sd131071;
  localparam logic signed [OUT_W-1:0] Y_MIN = -18'sd131072;

endpackage

// File: rtl/chevychev_hp_limit.sv
// Scales the accumulator back to sample units and limits it to 18 bits.
// CHEVYCHEV_HP_SAT_EN defined: clamp to [Y_MIN, Y_MAX]; otherwise keep the low bits (wrap).
module chevychev_hp_limit
  import chevychev_hp_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_y
);

  logic signed [ACC_W-1:0] w_shift;

  // Arithmetic shift floors toward -inf
  assign w_shift = i_acc >>> FRAC_BITS;

`ifdef CHEVYCHEV_HP_SAT_EN
  always_comb begin
    o_y = OUT_W'(w_shift);
    if (w_shift > ACC_W'(Y_MAX)) begin
      o_y = Y_MAX;
    end else if (w_shift < ACC_W'(Y_MIN)) begin
      o_y = Y_MIN;
    end
  end
`else
  assign o_y = OUT_W'(w_shift);
`endif

endmodule

// File: rtl/chevychev_highpass.sv
// Direct Form I biquad high-pass: one 8-bit sample in, one registered 18-bit sample out per clock.
// Output limiting (wrap or saturate via CHEVYCHEV_HP_SAT_EN) lives in chevychev_hp_limit.
module chevychev_highpass
  import chevychev_hp_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] B0 = B0_DEF,
  parameter logic signed [COEF_W-1:0] B1 = B1_DEF,
  parameter logic signed [COEF_W-1:0] B2 = B2_DEF,
  parameter logic signed [COEF_W-1:0] A1 = A1_DEF,
  parameter logic signed [COEF_W-1:0] A2 = A2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_in,
  output logic signed [OUT_W-1:0] data_out
);

  logic signed [IN_W-1:0]  r_x1, r_x2;
  logic signed [OUT_W-1:0] r_y1, r_y2;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [OUT_W-1:0] w_y;

  // All terms sign-extended to the accumulator width; the sum cannot overflow 32 bits
  assign w_acc = ACC_W'(B0) * ACC_W'(data_in)
               + ACC_W'(B1) * ACC_W'(r_x1)
               + ACC_W'(B2) * ACC_W'(r_x2)
               - ACC_W'(A1) * ACC_W'(r_y1)
               - ACC_W'(A2) * ACC_W'(r_y2);

  chevychev_hp_limit u_limit (
    .i_acc (w_acc),
    .o_y   (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
    end else begin
      r_x1 <= data_in;
      r_x2 <= r_x1;
      r_y1 <= w_y;
      r_y2 <= r_y1;
    end
  end

  // y[n-1] register doubles as the output register
  assign data_out = r_y1;

endmodule

// File: tb/tb_chevychev_highpass.sv
// Directed-vector bench: default-coefficient filter plus an overflow-coefficient instance.
module tb_chevychev_highpass;

  logic               clk;
  logic               rst;
  logic signed [7:0]  din;
  logic signed [7:0]  din_ovf;
  logic signed [17:0] dout;
  logic signed [17:0] dout_ovf;

  int n_vec;
  int n_err;

  chevychev_highpass u_dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (din),
    .data_out (dout)
  );

  chevychev_highpass #(
    .B0 (10'sd511),
    .B1 (10'sd511),
    .B2 (10'sd511),
    .A1 (-10'sd512),
    .A2 (10'sd0)
  ) u_dut_ovf (
    .clk      (clk),
    .rst      (rst),
    .data_in  (din_ovf),
    .data_out (dout_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Apply one sample, clock it in, sample output 1 time unit after the edge
  task automatic step(input logic signed [7:0] x);
    din = x;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp_imp[12] = '{25, -50, 18, 12, -5, -3, 1, 0, -1, 0, 0, 0};
  int exp_dc[9]   = '{25, -25, -7, 6, 1, -2, -1, 0, 0};
  int exp_nyq[14] = '{25, -75, 93, -82, 76, -80, 81, -80, 79, -80, 80, -80, 80, -80};
  int exp_ovf[8]  = '{253, 1013, 2786, 6332, 13424, 27608, 55976, 112712};

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    din     = 8'sh7f;
    din_ovf = 8'sd0;

    // Reset held across edges with a nonzero input
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("rst_hold[%0d]", i), dout, 0);
    end
    rst = 1'b0;
    din = 8'sd0;
    for (int i = 0; i < 2; i++) begin
      step(8'sd0);
      check_val($sformatf("post_rst[%0d]", i), dout, 0);
    end

    // Impulse
    for (int i = 0; i < 12; i++) begin
      step((i == 0) ? 8'sd100 : 8'sd0);
      check_val($sformatf("imp[%0d]", i), dout, exp_imp[i]);
    end

    // Impulse interrupted by an asynchronous reset between edges
    pulse_rst();
    step(8'sd100);
    step(8'sd0);
    step(8'sd0);
    check_val("imp_pre_async", dout, 18);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_now", dout, 0);
    #1;
    rst = 1'b0;
    step(8'sd0);
    check_val("after_async", dout, 0);
    for (int i = 0; i < 12; i++) begin
      step((i == 0) ? 8'sd100 : 8'sd0);
      check_val($sformatf("imp2[%0d]", i), dout, exp_imp[i]);
    end

    // DC: settles to zero and stays there
    pulse_rst();
    for (int i = 0; i < 40; i++) begin
      step(8'sd100);
      check_val($sformatf("dc[%0d]", i), dout, (i < 9) ? exp_dc[i] : 0);
    end

    // Nyquist: alternating input, steady magnitude 80
    pulse_rst();
    for (int i = 0; i < 14; i++) begin
      step((i % 2 == 0) ? 8'sd100 : -8'sd100);
      check_val($sformatf("nyq[%0d]", i), dout, exp_nyq[i]);
    end

    // Overflow instance: y[n] = 2*y[n-1] + 760 until it leaves the 18-bit range
    pulse_rst();
    din     = 8'sd0;
    din_ovf = 8'sd127;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("ovf[%0d]", i), dout_ovf, exp_ovf[i]);
    end
    @(posedge clk);
    #1;
`ifdef CHEVYCHEV_HP_SAT_EN
    check_val("ovf_sat[8]", dout_ovf, 131071);
`else
    check_val("ovf_wrap[8]", dout_ovf, -35960);
`endif
    @(posedge clk);
    #1;
`ifdef CHEVYCHEV_HP_SAT_EN
    check_val("ovf_sat[9]", dout_ovf, 131071);
`else
    check_val("ovf_wrap[9]", dout_ovf, -71160);
`endif
    check_val("ovf_main_idle", dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
